// File: rtl/audio_pkg.sv
// Shared audio constants: voice count, equal-temperament half-period table (C4..B4 at 50 MHz),
// default sample divider and per-voice amplitude.
package audio_pkg;

    localparam int unsigned NUM_VOICES     = 12;
    localparam int unsigned CNT_W          = 17;
    localparam int unsigned SAMPLE_W       = 32;
    localparam int unsigned DEF_SAMPLE_DIV = 1042;

    localparam logic signed [SAMPLE_W-1:0] DEF_AMP = 32'sh0100_0000;

    // round(50e6 / (2 * f_k)), k = 0 (C4) .. 11 (B4)
    localparam logic [CNT_W-1:0] HALF_PERIOD [NUM_VOICES] = '{
        17'd95556, 17'd90193, 17'd85131, 17'd80353,
        17'd75843, 17'd71586, 17'd67569, 17'd63776,
        17'd60197, 17'd56818, 17'd53629, 17'd50619
    };

endpackage

// File: rtl/square_voice.sv
// One free-running square-wave voice: half-period counter plus phase bit.
module square_voice
    import audio_pkg::*;
#(
    parameter logic [CNT_W-1:0] HALF_CYCLES = 17'd95556
) (
    input  logic CLOCK_50,
    input  logic nReset,
    output logic phase
);

    logic [CNT_W-1:0] cnt;

    // Phase toggles each time the counter completes a half period
    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == CNT_W'(HALF_CYCLES - 17'd1)) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tone_mixer.sv
// Twelve-voice square-wave tone mixer feeding a codec FIFO with a sticky overrun flag.
module tone_mixer
    import audio_pkg::*;
#(
    parameter int unsigned                  SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter logic signed [SAMPLE_W-1:0]   AMP        = DEF_AMP
) (
    input  logic                    CLOCK_50,
    input  logic                    nReset,
    input  logic [NUM_VOICES-1:0]   select_note,
    input  logic                    bpm_step,
    input  logic                    play_en,
    input  logic                    audio_out_allowed,
    output logic                    write_audio_out,
    output logic [SAMPLE_W-1:0]     left_channel_audio_out,
    output logic [SAMPLE_W-1:0]     right_channel_audio_out,
    output logic [NUM_VOICES-1:0]   voice_active,
    output logic                    overrun
);

    localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic [2:0]                 step_sync;
    logic [1:0]                 play_sync;
    logic                       step_rise_c;
    logic                       play_on_c;
    logic                       load_q;
    logic [NUM_VOICES-1:0]      phase;
    logic [DIV_W-1:0]           div_cnt;
    logic                       tick_c;
    logic signed [SAMPLE_W-1:0] mix_c;
    logic [SAMPLE_W-1:0]        sample;
    logic                       pending;

    // Two-flop synchronizers; the third step flop only serves edge detection
    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            step_sync <= '0;
            play_sync <= '0;
            load_q    <= 1'b0;
        end else begin
            step_sync <= {step_sync[1:0], bpm_step};
            play_sync <= {play_sync[0], play_en};
            load_q    <= step_rise_c;
        end
    end

    assign step_rise_c = step_sync[1] & ~step_sync[2];
    assign play_on_c   = play_sync[1];

    // select_note is stable around a step, so it is sampled without per-bit sync
    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            voice_active <= '0;
        end else if (!play_on_c) begin
            voice_active <= '0;
        end else if (load_q) begin
            voice_active <= select_note;
        end
    end

    for (genvar k = 0; k < NUM_VOICES; k++) begin : g_voice
        square_voice #(
            .HALF_CYCLES (HALF_PERIOD[k])
        ) u_voice (
            .CLOCK_50 (CLOCK_50),
            .nReset   (nReset),
            .phase    (phase[k])
        );
    end

    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            div_cnt <= '0;
        end else if (tick_c) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign tick_c = (div_cnt == DIV_W'(SAMPLE_DIV - 1));

    // 12 * AMP fits in 31 bits, so the sum never saturates
    always_comb begin
        mix_c = '0;
        for (int k = 0; k < NUM_VOICES; k++) begin
            if (voice_active[k]) begin
                mix_c = mix_c + (phase[k] ? AMP : -AMP);
            end
        end
    end

    // A load never coincides with a write, so the strobe always carries the sample it was issued for
    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            sample          <= '0;
            pending         <= 1'b0;
            write_audio_out <= 1'b0;
            overrun         <= 1'b0;
        end else begin
            write_audio_out <= 1'b0;
            if (tick_c) begin
                sample  <= SAMPLE_W'(mix_c);
                pending <= 1'b1;
                if (pending) begin
                    overrun <= 1'b1;
                end
            end else if (pending && audio_out_allowed) begin
                write_audio_out <= 1'b1;
                pending         <= 1'b0;
            end
        end
    end

    assign left_channel_audio_out  = sample;
    assign right_channel_audio_out = sample;

endmodule

// File: tb/tb_tone_mixer.sv
// Directed self-checking bench for tone_mixer with hand-computed sample values.
module tb_tone_mixer;

    localparam logic [31:0] P1   = 32'h0100_0000;  // +AMP
    localparam logic [31:0] M1   = 32'hFF00_0000;  // -AMP
    localparam logic [31:0] M12  = 32'hF400_0000;  // all 12 voices low
    localparam logic [31:0] M10  = 32'hF600_0000;  // B4 high, other 11 low

    logic        CLOCK_50;
    logic        nReset;
    logic [11:0] select_note;
    logic        bpm_step;
    logic        play_en;
    logic        audio_out_allowed;
    logic        write_audio_out;
    logic [31:0] left_channel_audio_out;
    logic [31:0] right_channel_audio_out;
    logic [11:0] voice_active;
    logic        overrun;

    int n_cmp;
    int n_bad;
    int cyc;

    tone_mixer dut (
        .CLOCK_50                (CLOCK_50),
        .nReset                  (nReset),
        .select_note             (select_note),
        .bpm_step                (bpm_step),
        .play_en                 (play_en),
        .audio_out_allowed       (audio_out_allowed),
        .write_audio_out         (write_audio_out),
        .left_channel_audio_out  (left_channel_audio_out),
        .right_channel_audio_out (right_channel_audio_out),
        .voice_active            (voice_active),
        .overrun                 (overrun)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    // Cycles since the last reset release
    always @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_write(input int max_cyc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge CLOCK_50);
            if (write_audio_out) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic count_writes(input int n_cyc, output int cnt);
        cnt = 0;
        for (int i = 0; i < n_cyc; i++) begin
            @(negedge CLOCK_50);
            if (write_audio_out) cnt++;
        end
    endtask

    // Step pulse then check voice_active four cycles after the rising edge
    task automatic step_and_check(input string tag, input logic [11:0] notes);
        select_note = notes;
        bpm_step    = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        bpm_step    = 1'b0;
        @(negedge CLOCK_50);
        check_eq(tag, 32'(voice_active), 32'(notes));
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_wr"},  32'(write_audio_out), 32'd0);
        check_eq({tag, "_l"},   left_channel_audio_out, 32'd0);
        check_eq({tag, "_r"},   right_channel_audio_out, 32'd0);
        check_eq({tag, "_va"},  32'(voice_active), 32'd0);
        check_eq({tag, "_ovr"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        bit seen;
        int n;

        n_cmp = 0;
        n_bad = 0;
        nReset = 1'b0;
        select_note = '0;
        bpm_step = 1'b0;
        play_en = 1'b0;
        audio_out_allowed = 1'b0;

        repeat (3) @(negedge CLOCK_50);
        check_outputs_zero("rst");
        nReset = 1'b1;
        play_en = 1'b1;
        audio_out_allowed = 1'b1;
        repeat (3) @(negedge CLOCK_50);

        // Single voice C4, phase 0 -> -AMP
        step_and_check("va_001", 12'h001);
        wait_write(1200, seen);
        check_eq("wr1_seen", 32'(seen), 32'd1);
        check_eq("c4_left", left_channel_audio_out, M1);
        check_eq("c4_right", right_channel_audio_out, M1);
        n = 0;
        for (int i = 1; i <= 1200; i++) begin
            @(negedge CLOCK_50);
            if (write_audio_out) begin
                n = i;
                break;
            end
        end
        check_eq("wr_interval", 32'(n), 32'd1042);
        @(negedge CLOCK_50);
        check_eq("wr_width", 32'(write_audio_out), 32'd0);

        // All voices, all phases still low
        step_and_check("va_fff", 12'hFFF);
        wait_write(1200, seen);
        wait_write(1200, seen);
        check_eq("wr2_seen", 32'(seen), 32'd1);
        check_eq("fff_left", left_channel_audio_out, M12);
        check_eq("fff_lr", right_channel_audio_out, left_channel_audio_out);

        // FIFO blocked across two ticks -> overrun, then one write of the latest sample
        audio_out_allowed = 1'b0;
        count_writes(2500, n);
        check_eq("blocked_writes", 32'(n), 32'd0);
        check_eq("overrun_set", 32'(overrun), 32'd1);
        audio_out_allowed = 1'b1;
        wait_write(5, seen);
        check_eq("release_seen", 32'(seen), 32'd1);
        check_eq("release_left", left_channel_audio_out, M12);
        count_writes(20, n);
        check_eq("release_once", 32'(n), 32'd0);
        check_eq("overrun_sticky", 32'(overrun), 32'd1);

        // Reset while a sample is pending
        audio_out_allowed = 1'b0;
        repeat (1100) @(negedge CLOCK_50);
        nReset = 1'b0;
        #1;
        check_outputs_zero("midrst");
        @(negedge CLOCK_50);
        nReset = 1'b1;
        audio_out_allowed = 1'b1;
        count_writes(1030, n);
        check_eq("post_rst_quiet", 32'(n), 32'd0);
        wait_write(30, seen);
        check_eq("post_rst_seen", 32'(seen), 32'd1);
        check_eq("post_rst_left", left_channel_audio_out, 32'd0);

        // play_en drop clears the voice set and silences the mix
        step_and_check("va_010", 12'h010);
        play_en = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check_eq("play_off_va", 32'(voice_active), 32'd0);
        wait_write(1200, seen);
        wait_write(1200, seen);
        check_eq("play_off_seen", 32'(seen), 32'd1);
        check_eq("play_off_left", left_channel_audio_out, 32'd0);
        step_and_check("va_blocked", 12'h000);
        select_note = 12'hFFF;

        // Re-enable all voices; B4 flips at 50619 cycles, A#4 not until 53629
        play_en = 1'b1;
        step_and_check("va_fff2", 12'hFFF);
        wait_write(1200, seen);
        wait_write(1200, seen);
        check_eq("pre_b4_left", left_channel_audio_out, M12);
        while (cyc < 51500) @(negedge CLOCK_50);
        wait_write(1200, seen);
        check_eq("b4_seen", 32'(seen), 32'd1);
        check_eq("b4_left", left_channel_audio_out, M10);
        check_eq("b4_lr", right_channel_audio_out, M10);
        check_eq("b4_no_ovr", 32'(overrun), 32'd0);
        check_eq("p1_sanity", P1 + M1, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
